// File: rtl/strobe_to_axis_if.sv
// AXI-Stream sample channel used on the output of strobe_to_axis.
//   tdata  : sample data
//   tlast  : last sample of a packet
//   tvalid : sample present
//   tready : consumer accepts sample
// master drives data/last/valid, slave drives ready.
interface strobe_to_axis_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/strobe_to_axis.sv
// Strobe-qualified sample input to AXI-Stream master with packetization.
// Samples accepted on strobe_in are buffered (memory FIFO + output register)
// and emitted in order; tlast marks every spp-th accepted sample. Samples that
// arrive while the buffer is full are dropped and counted.
//   clk, reset        : clock, synchronous active-high reset
//   in, strobe_in     : sample data and its qualifier (no backpressure)
//   spp               : samples per packet, 0 treated as 1
//   o                 : AXI-Stream master (tdata/tlast/tvalid, tready)
//   clear_overflow    : pulse clearing overflow and overflow_count
//   overflow          : sticky drop flag
//   overflow_count    : saturating drop counter
module strobe_to_axis #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FIFO_SIZE = 4,
    parameter int unsigned SPP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic                 strobe_in,
    input  logic [SPP_WIDTH-1:0] spp,
    input  logic                 clear_overflow,
    output logic                 overflow,
    output logic [15:0]          overflow_count,
    strobe_to_axis_if.master     o
);
    localparam int unsigned DEPTH = 1 << FIFO_SIZE;
    localparam int unsigned CNT_W = FIFO_SIZE + 1;
    localparam int unsigned ENT_W = WIDTH + 1;

    // Buffer storage: {data, last}
    logic [ENT_W-1:0]     mem [DEPTH];
    logic [FIFO_SIZE-1:0] wr_ptr;
    logic [FIFO_SIZE-1:0] rd_ptr;
    logic [CNT_W-1:0]     mem_cnt;

    // Output register stage
    logic                 out_valid;
    logic                 out_last;
    logic [WIDTH-1:0]     out_data;

    // Packetization state
    logic [SPP_WIDTH-1:0] pkt_cnt;
    logic [SPP_WIDTH-1:0] spp_lat;
    logic [SPP_WIDTH-1:0] spp_eff;
    logic [SPP_WIDTH-1:0] spp_cur;
    logic                 last_flag;

    logic full;
    logic pop;
    logic push;
    logic load;
    logic drop;

    // Handshake and buffer control; occupancy counts the output register too
    always_comb begin
        pop       = out_valid & o.tready;
        full      = (mem_cnt + CNT_W'(out_valid)) == CNT_W'(DEPTH);
        push      = strobe_in & (~full | pop);
        drop      = strobe_in & full & ~pop;
        load      = (mem_cnt != '0) & (~out_valid | pop);
        spp_eff   = (spp == '0) ? SPP_WIDTH'(1) : spp;
        // spp is sampled only at the first sample of each packet
        spp_cur   = (pkt_cnt == '0) ? spp_eff : spp_lat;
        last_flag = pkt_cnt == (spp_cur - SPP_WIDTH'(1));
    end

    // Sample memory write (contents need no reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in, last_flag};
        end
    end

    // Output data register (don't-care while tvalid is low)
    always_ff @(posedge clk) begin
        if (load) begin
            out_data <= mem[rd_ptr][ENT_W-1:1];
        end
    end

    // Buffer pointers, occupancy and output valid/last
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_SIZE'(1);
            end
            if (load) begin
                rd_ptr   <= rd_ptr + FIFO_SIZE'(1);
                out_last <= mem[rd_ptr][0];
            end
            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
                2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            if (load) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Packet sample counter; advances on accepted samples only
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt <= '0;
            spp_lat <= SPP_WIDTH'(1);
        end else if (push) begin
            if (pkt_cnt == '0) begin
                spp_lat <= spp_eff;
            end
            pkt_cnt <= last_flag ? '0 : pkt_cnt + SPP_WIDTH'(1);
        end
    end

    // Drop tracking; a drop coinciding with a clear restarts the count at 1
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                overflow_count <= 16'd1;
            end else if (overflow_count != 16'hFFFF) begin
                overflow_count <= overflow_count + 16'd1;
            end
        end else if (clear_overflow) begin
            overflow       <= 1'b0;
            overflow_count <= '0;
        end
    end

    assign o.tdata  = out_data;
    assign o.tlast  = out_last;
    assign o.tvalid = out_valid;

endmodule

// File: tb/tb_strobe_to_axis.sv
// Self-checking bench for strobe_to_axis: a reference model at each rising
// edge queues expected samples; a monitor on the falling edge pops and
// compares them, and checks hold/empty/overflow behaviour.
module tb_strobe_to_axis;
    localparam int WIDTH     = 16;
    localparam int FIFO_SIZE = 4;
    localparam int SPP_WIDTH = 16;
    localparam int DEPTH     = 1 << FIFO_SIZE;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [WIDTH-1:0]     in;
    logic                 strobe_in;
    logic [SPP_WIDTH-1:0] spp;
    logic                 clear_overflow;
    logic                 overflow;
    logic [15:0]          overflow_count;

    strobe_to_axis_if #(.WIDTH(WIDTH)) axis ();

    strobe_to_axis #(
        .WIDTH    (WIDTH),
        .FIFO_SIZE(FIFO_SIZE),
        .SPP_WIDTH(SPP_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in            (in),
        .strobe_in     (strobe_in),
        .spp           (spp),
        .clear_overflow(clear_overflow),
        .overflow      (overflow),
        .overflow_count(overflow_count),
        .o             (axis)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic [31:0]      cyc;
    } exp_t;

    exp_t             exp_q[$];
    logic             last_log[$];
    logic [WIDTH-1:0] data_log[$];

    int total = 0;
    int bad   = 0;

    // model state
    int          occ = 0;
    int          m_cnt = 0;
    int          m_spp = 1;
    logic        m_ovf = 1'b0;
    logic [15:0] m_ovc = 16'd0;
    bit          pop_pend = 1'b0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model of acceptance, packetization and drop counting
    always @(posedge clk) begin
        bit   acc;
        bit   drp;
        logic lst;
        cyc++;
        if (reset) begin
            exp_q.delete();
            occ        = 0;
            m_cnt      = 0;
            m_ovf      = 1'b0;
            m_ovc      = 16'd0;
            stall_prev = 1'b0;
        end else begin
            acc = strobe_in && (occ < DEPTH || pop_pend);
            drp = strobe_in && !acc;
            if (pop_pend) occ--;
            if (acc) begin
                if (m_cnt == 0) m_spp = (spp == 0) ? 1 : int'(spp);
                lst   = (m_cnt == m_spp - 1);
                m_cnt = lst ? 0 : m_cnt + 1;
                exp_q.push_back('{data: in, last: lst, cyc: 32'(cyc)});
                occ++;
            end
            if (drp) begin
                m_ovf = 1'b1;
                if (clear_overflow) m_ovc = 16'd1;
                else if (m_ovc != 16'hFFFF) m_ovc = m_ovc + 16'd1;
            end else if (clear_overflow) begin
                m_ovf = 1'b0;
                m_ovc = 16'd0;
            end
        end
        pop_pend = 1'b0;
    end

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (stall_prev) begin
                check("hold_valid", 32'(axis.tvalid), 32'd1);
                check("hold_data", 32'(axis.tdata), 32'(prev_data));
                check("hold_last", 32'(axis.tlast), 32'(prev_last));
            end
            if (occ == 0) check("empty_valid", 32'(axis.tvalid), 32'd0);
            check("ovf", 32'(overflow), 32'(m_ovf));
            check("ovf_count", 32'(overflow_count), 32'(m_ovc));
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexp", 32'(axis.tvalid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(axis.tdata), 32'(e.data));
                    check("last", 32'(axis.tlast), 32'(e.last));
                    if (lat_chk) check("latency", 32'(cyc) - e.cyc, 32'd1);
                    last_log.push_back(axis.tlast);
                    data_log.push_back(axis.tdata);
                end
                pop_pend = 1'b1;
            end
            stall_prev = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        strobe_in = 1'b1;
        in        = v;
        tick();
        strobe_in = 1'b0;
    endtask

    task automatic drain();
        axis.tready = 1'b1;
        for (int i = 0; i < 200 && occ != 0; i++) tick();
        check("drain", 32'(occ), 32'd0);
        tick();
    endtask

    function automatic logic [31:0] last_vec();
        logic [31:0] v;
        v = '0;
        foreach (last_log[i]) v[i] = last_log[i];
        return v;
    endfunction

    task automatic clear_logs();
        last_log.delete();
        data_log.delete();
    endtask

    initial begin
        reset          = 1'b1;
        strobe_in      = 1'b0;
        in             = '0;
        spp            = 16'd4;
        clear_overflow = 1'b0;
        axis.tready    = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        reset  = 1'b0;
        check("rst_valid", 32'(axis.tvalid), 32'd0);
        check("rst_last", 32'(axis.tlast), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(overflow_count), 32'd0);

        // basic streaming, spp=4
        axis.tready = 1'b1;
        clear_logs();
        lat_chk = 1'b1;
        for (int v = 1; v <= 8; v++) push(WIDTH'(v));
        repeat (3) tick();
        lat_chk = 1'b0;
        check("t1_n", 32'(last_log.size()), 32'd8);
        check("t1_last", last_vec(), 32'h88);
        check("t1_ovf", 32'(overflow), 32'd0);

        // overfill with backpressure, spp=3
        spp = 16'd3;
        axis.tready = 1'b0;
        clear_logs();
        for (int v = 1; v <= DEPTH + 3; v++) push(WIDTH'(v));
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_count", 32'(overflow_count), 32'd3);
        drain();
        check("t2_n", 32'(last_log.size()), 32'd16);
        check("t2_last", last_vec(), 32'h4924);
        check("t2_first", 32'(data_log[0]), 32'd1);
        check("t2_final", 32'(data_log[data_log.size()-1]), 32'd16);

        // push and pop on the same edge while full
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        axis.tready = 1'b0;
        spp = 16'd4;
        for (int v = 101; v < 101 + DEPTH; v++) push(WIDTH'(v));
        check("t3_pre_count", 32'(overflow_count), 32'd0);
        axis.tready = 1'b1;
        push(WIDTH'(200));
        axis.tready = 1'b0;
        check("t3_count", 32'(overflow_count), 32'd0);
        push(WIDTH'(201));
        check("t3_still_full", 32'(overflow_count), 32'd1);
        drain();

        // spp change mid-packet, then spp=0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        spp = 16'd4;
        axis.tready = 1'b1;
        clear_logs();
        push(WIDTH'(1));
        push(WIDTH'(2));
        spp = 16'd2;
        for (int v = 3; v <= 8; v++) push(WIDTH'(v));
        spp = 16'd0;
        for (int v = 9; v <= 11; v++) push(WIDTH'(v));
        repeat (4) tick();
        check("t4_n", 32'(last_log.size()), 32'd11);
        check("t4_last", last_vec(), 32'h7A8);

        // clear coincident with drop, clear alone, saturation
        axis.tready = 1'b0;
        spp = 16'd4;
        for (int v = 0; v < DEPTH + 2; v++) push(WIDTH'(300 + v));
        check("t5_pre", 32'(overflow_count), 32'd2);
        clear_overflow = 1'b1;
        push(WIDTH'(400));
        clear_overflow = 1'b0;
        check("t5_clr_drop_cnt", 32'(overflow_count), 32'd1);
        check("t5_clr_drop_ovf", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t5_clr_cnt", 32'(overflow_count), 32'd0);
        check("t5_clr_ovf", 32'(overflow), 32'd0);
        strobe_in = 1'b1;
        in = WIDTH'(16'hBEEF);
        repeat (70000) tick();
        strobe_in = 1'b0;
        check("t5_sat", 32'(overflow_count), 32'hFFFF);
        check("t5_sat_ovf", 32'(overflow), 32'd1);
        drain();

        // reset with samples buffered mid-packet
        axis.tready = 1'b0;
        spp = 16'd4;
        for (int v = 1; v <= 5; v++) push(WIDTH'(500 + v));
        check("t6_pre_ovf", 32'(overflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", 32'(axis.tvalid), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_count", 32'(overflow_count), 32'd0);
        axis.tready = 1'b1;
        clear_logs();
        for (int v = 1; v <= 4; v++) push(WIDTH'(600 + v));
        repeat (3) tick();
        check("t6_n", 32'(last_log.size()), 32'd4);
        check("t6_last", last_vec(), 32'h8);
        check("t6_first", 32'(data_log[0]), 32'd601);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
